comparador_serial: RTL
======================

COMPARADOR_SERIAL -- requirements
Module: comparador_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have parameter SIGNED, default 0; 0 means unsigned and 1 means two's-complement operands.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin a comparison.
REQ-006 SHALL have port a, input, WIDTH bits: operand A.
REQ-007 SHALL have port b, input, WIDTH bits: operand B.
REQ-008 SHALL have port chave, input, 1 bit: mode select; 0 tests A<B and 1 tests A>B.
REQ-009 SHALL have port s, output, 1 bit: result of the selected test.
REQ-010 SHALL have port eq, output, 1 bit: high when A==B.
REQ-011 SHALL have port busy, output, 1 bit: high while a comparison is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a result is valid.

Function
REQ-013 SHALL implement an FSM with states IDLE, COMPARE and DONE.
REQ-014 IDLE with start=1 SHALL, at the edge: register a, b and chave; set the bit index to WIDTH-1; clear s and eq; move to COMPARE.
REQ-015 Changes to a, b or chave after start is accepted SHALL NOT affect the running comparison.
REQ-016 COMPARE SHALL examine one registered bit pair per cycle, MSB first; busy=1 for the whole of COMPARE.
REQ-017 In COMPARE, if the bits differ, the FSM SHALL resolve gt/lt from that bit, register s, and move to DONE (early termination).
REQ-018 When SIGNED=1, the gt/lt sense SHALL be inverted at bit WIDTH-1 only.
REQ-019 In COMPARE, if the bits are equal and the index is 0, the FSM SHALL set eq=1 and s=0, then move to DONE.
REQ-020 In COMPARE, if the bits are equal and the index is not 0, the FSM SHALL decrement the index and stay in COMPARE.
REQ-021 The registered result SHALL be s = chave_reg ? (A>B) : (A<B).
REQ-022 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-023 Latency SHALL be k+1 cycles from the start-accept edge to done high, where k is the number of equal leading bits (0..WIDTH-1); equal operands take WIDTH cycles.
REQ-024 s and eq SHALL hold their value after done until the next accepted start.
REQ-025 start SHALL be ignored in COMPARE and in DONE, with no queuing.
REQ-026 A start held high continuously SHALL produce back-to-back comparisons, accepted on each IDLE cycle.

Reset
REQ-027 reset=1 at an edge SHALL force IDLE with s=0, eq=0, busy=0, done=0, operand registers cleared and index=WIDTH-1.
REQ-028 reset SHALL take priority over start and over any in-progress comparison; an aborted comparison SHALL never pulse done.

Structure
REQ-029 FSM state encodings and the WIDTH range limits SHALL live in shared package comparador_pkg.
REQ-030 The per-bit decision SHALL be a sub-module cmp_bit: inputs ai, bi and msb_inv; outputs gt and lt; purely combinational.
REQ-031 The index counter SHALL be $clog2(WIDTH) bits wide, and the FSM SHALL be a single registered process.

Verification
REQ-032 Reset check (WIDTH=8): assert reset for 2 cycles -> s=0, eq=0, busy=0, done=0.
REQ-033 Early termination at MSB (WIDTH=8, SIGNED=0): a=0x80, b=0x7F, chave=1, start -> done 1 cycle after accept, s=1, eq=0. Same with SIGNED=1 -> s=0.
REQ-034 Equal operands: a=b=0x5A, chave=0 -> busy for 8 cycles, done on cycle 8, s=0, eq=1.
REQ-035 Difference at LSB: a=0x12, b=0x13, chave=0 -> done on cycle 8, s=1. Repeat with chave=1 -> s=0.
REQ-036 Busy and reset interaction: start pulsed again during COMPARE is ignored and the result is unchanged. Reset asserted mid-COMPARE -> IDLE next edge, no done pulse. A subsequent start works normally.
REQ-037 Back-to-back: start held high for 3 comparisons -> 3 done pulses, each followed by one IDLE cycle before the next accept.

Source files
------------

// File: rtl/comparador_pkg.sv
// Shared definitions for the serial magnitude comparator.
// Holds FSM state encodings, legal width range and the per-bit decision bundle.
package comparador_pkg;

   // Legal operand width range
   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COMPARE = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   // Decision for one bit pair
   typedef struct packed {
      logic gt;
      logic lt;
   } bit_dec_t;

   function automatic bit width_ok(input int w);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
   endfunction

endpackage

// File: rtl/comparador_serial_cmp_bit.sv
// Single bit-pair decision for the serial comparator (purely combinational).
// Ports: ai, bi = operand bits; msb_inv = swap sense (sign bit); gt/lt = result.
module cmp_bit (
   input  logic ai,
   input  logic bi,
   input  logic msb_inv,
   output logic gt,
   output logic lt
);

   logic raw_gt;
   logic raw_lt;

   assign raw_gt = ai & ~bi;
   assign raw_lt = ~ai & bi;

   // A set sign bit means a smaller two's-complement value
   assign gt = msb_inv ? raw_lt : raw_gt;
   assign lt = msb_inv ? raw_gt : raw_lt;

endmodule

// File: rtl/comparador_serial.sv
// Serial MSB-first magnitude comparator with early termination.
// Ports: clk, reset (sync, high); start, a, b, chave (0: A<B, 1: A>B) in;
//        s (test result), eq (A==B), busy (comparing), done (1-cycle pulse) out.
module comparador_serial
   import comparador_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             chave,
   output logic             s,
   output logic             eq,
   output logic             busy,
   output logic             done
);

   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("comparador_serial: WIDTH out of range");
   end

   logic [1:0]       state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             chave_r;
   logic [IW-1:0]    idx;
   logic             s_r;
   logic             eq_r;

   logic     ai;
   logic     bi;
   logic     msb_inv;
   bit_dec_t dec;
   logic     differ;
   logic     res_s;

   assign ai      = a_r[idx];
   assign bi      = b_r[idx];
   assign msb_inv = SIGNED && (idx == IDX_TOP);

   cmp_bit u_cmp_bit (
      .ai      (ai),
      .bi      (bi),
      .msb_inv (msb_inv),
      .gt      (dec.gt),
      .lt      (dec.lt)
   );

   // First differing bit from the top decides the ordering
   assign differ = dec.gt | dec.lt;
   assign res_s  = chave_r ? dec.gt : dec.lt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         a_r     <= '0;
         b_r     <= '0;
         chave_r <= 1'b0;
         idx     <= IDX_TOP;
         s_r     <= 1'b0;
         eq_r    <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
                  chave_r <= chave;
                  idx     <= IDX_TOP;
                  s_r     <= 1'b0;
                  eq_r    <= 1'b0;
                  state   <= ST_COMPARE;
               end
            end
            ST_COMPARE: begin
               if (differ) begin
                  s_r   <= res_s;
                  state <= ST_DONE;
               end else if (idx == '0) begin
                  eq_r  <= 1'b1;
                  s_r   <= 1'b0;
                  state <= ST_DONE;
               end else begin
                  idx <= idx - IW'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign s    = s_r;
   assign eq   = eq_r;
   assign busy = (state == ST_COMPARE);
   assign done = (state == ST_DONE);

endmodule
